cp0_timer_int_ctrl: RTL



---
 rtl/cp0_timer_int_ctrl_if.sv | 11 +
 rtl/cp0_timer_int_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/cp0_timer_int_ctrl_if.sv
// cp0_timer_int_ctrl_if: mtc0/mfc0 register access port of the CP0 timer/interrupt unit.
interface cp0_timer_int_ctrl_if;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    modport master (output stall, we, waddr, wdata, raddr, input rdata);
    modport slave (input stall, we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/cp0_timer_int_ctrl.sv
// cp0_timer_int_ctrl: CP0 Count/Compare/Random/Wired and Cause.IP/TI with a registered
// interrupt request built from synchronised hardware lines and the Status enables.
module cp0_timer_int_ctrl #(
    parameter int NUM_HW_INT   = 6,
    parameter int COUNT_DIV    = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int TLB_LINE_NUM = 16,
    parameter int TIMER_ON_IP7 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_timer_int_ctrl_if.slave   bus,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic [7:0]            status_im,
    input  logic                  tlbwr_i,
    output logic [31:0]           count_o,
    output logic [31:0]           compare_o,
    output logic [31:0]           random_o,
    output logic [7:0]            cause_ip_o,
    output logic                  cause_ti_o,
    output logic                  int_req_o
);
    localparam int RW = $clog2(TLB_LINE_NUM);
    localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(TLB_LINE_NUM - 1);
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);
    localparam logic [4:0] R_RANDOM = 5'd1, R_WIRED = 5'd6, R_COUNT = 5'd9,
                           R_COMPARE = 5'd11, R_CAUSE = 5'd13;

    logic [31:0] count, compare;
    logic [PW-1:0] pre;
    logic [RW-1:0] random, wired;
    logic [1:0] sw_ip;
    logic [SYNC_STAGES-1:0][NUM_HW_INT-1:0] sync;
    logic [7:0] ip;
    logic ti, inc_d, tick, adv, wr, w_count, w_compare, w_cause, w_wired;

    assign wr        = bus.we & ~bus.stall;
    assign w_count   = wr & (bus.waddr == R_COUNT);
    assign w_compare = wr & (bus.waddr == R_COMPARE);
    assign w_cause   = wr & (bus.waddr == R_CAUSE);
    assign w_wired   = wr & (bus.waddr == R_WIRED);
    assign tick      = pre == PMAX;
    // Random steps every cycle anyway; a committed tlbwr is simply one more reason to step.
    assign adv       = 1'b1 | tlbwr_i;

    always_comb begin
        ip = 8'b0;
        ip[1:0] = sw_ip;
        ip[2 +: NUM_HW_INT] = sync[SYNC_STAGES-1];
        ip[7] = ip[7] | (TIMER_ON_IP7 != 0 ? ti : 1'b0);
    end

    // inc_d marks that Count moved by increment last edge, so TI fires on the edge, not the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            pre     <= '0;
            inc_d   <= 1'b0;
            ti      <= 1'b0;
            sw_ip   <= '0;
            sync    <= '0;
            wired   <= '0;
            random  <= RMAX;
            int_req_o <= 1'b0;
        end else begin
            pre     <= (w_count | tick) ? '0 : pre + 1'b1;
            count   <= w_count ? bus.wdata : count + 32'(tick);
            inc_d   <= tick & ~w_count;
            compare <= w_compare ? bus.wdata : compare;
            ti      <= w_compare ? 1'b0 : ti | (inc_d & (count == compare));
            sw_ip   <= w_cause ? bus.wdata[9:8] : sw_ip;
            sync[0] <= int_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync[i] <= sync[i-1];
            wired   <= w_wired ? bus.wdata[RW-1:0] : wired;
            random  <= (w_wired | (random == wired)) ? RMAX : (adv ? random - 1'b1 : random);
            int_req_o <= status_ie & ~status_exl & |(status_im & ip);
        end
    end

    assign bus.rdata = bus.raddr == R_COUNT   ? count :
                       bus.raddr == R_COMPARE ? compare :
                       bus.raddr == R_RANDOM  ? 32'(random) :
                       bus.raddr == R_WIRED   ? 32'(wired) :
                       bus.raddr == R_CAUSE   ? {1'b0, ti, 14'b0, ip, 8'b0} : 32'b0;

    assign count_o    = count;
    assign compare_o  = compare;
    assign random_o   = 32'(random);
    assign cause_ip_o = ip;
    assign cause_ti_o = ti;
endmodule
